// File: rtl/factory_test_pkg.sv
// ---------------------------------------------------------------------------
// factory_test_pkg
// Shared constants for the factory test sequencer: FSM state encodings,
// phase-enable bit positions, per-phase last-step values and two small
// helpers that walk the phase order.
// No ports (package).
// ---------------------------------------------------------------------------
package factory_test_pkg;

  // FSM state encodings. The four pattern phases are numbered consecutively
  // so that "the next phase" is simply the next larger enabled encoding.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WALK1  = 3'd1;
  localparam logic [2:0] ST_WALK0  = 3'd2;
  localparam logic [2:0] ST_COUNT  = 3'd3;
  localparam logic [2:0] ST_LOOP   = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  // Bit positions inside the phase-enable mask.
  localparam int MASK_WALK1 = 0;
  localparam int MASK_WALK0 = 1;
  localparam int MASK_COUNT = 2;
  localparam int MASK_LOOP  = 3;

  // Last step index of the fixed-length phases.
  localparam logic [7:0] WALK_LAST  = 8'd7;
  localparam logic [7:0] COUNT_LAST = 8'd255;

  // True for the four states that drive a pattern onto the pins.
  function automatic logic is_phase(input logic [2:0] state);
    return (state >= ST_WALK1) && (state <= ST_LOOP);
  endfunction

  // First enabled phase strictly after 'cur', or FINISH when none remain.
  // Mask bit i enables the phase whose encoding is i+1.
  function automatic logic [2:0] next_phase(input logic [2:0] cur,
                                            input logic [3:0] mask);
    logic [2:0] nxt;
    nxt = ST_FINISH;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i + 1) > cur)) begin
        nxt = 3'(i + 1);
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ft_pattern_gen.sv
// ---------------------------------------------------------------------------
// ft_pattern_gen
// Purely combinational pattern lookup: maps the sequencer state and the step
// index within that state onto the 8-bit value to drive on the IO bank.
// Ports:
//   i_state    in  3  sequencer state encoding (factory_test_pkg ST_*)
//   i_step     in  8  step index inside the current phase
//   o_pattern  out 8  pattern for that state/step (0 outside the phases)
// ---------------------------------------------------------------------------
module ft_pattern_gen
  import factory_test_pkg::*;
(
  input  logic [2:0] i_state,
  input  logic [7:0] i_step,
  output logic [7:0] o_pattern
);

  // Walking phases only ever see steps 0..7, so the low three bits select the
  // bit position. The loopback phase pairs the step nibble with its inverse so
  // that every pin toggles across the phase.
  always_comb begin
    o_pattern = 8'h00;
    case (i_state)
      ST_WALK1: o_pattern = 8'h01 << i_step[2:0];
      ST_WALK0: o_pattern = ~(8'h01 << i_step[2:0]);
      ST_COUNT: o_pattern = i_step;
      ST_LOOP:  o_pattern = {i_step[3:0], ~i_step[3:0]};
      default:  o_pattern = 8'h00;
    endcase
  end

endmodule

// File: rtl/factory_test_sequencer.sv
// ---------------------------------------------------------------------------
// factory_test_sequencer
// Steps pin-level test patterns (walking-1, walking-0, 8-bit count, nibble
// loopback) onto the IO bank, holds each step for a programmable dwell,
// compares the pin readback on the last cycle of every step and reports a
// mismatch count plus pass/done status.
// Ports:
//   i_clk        in  1        clock
//   i_rst_n      in  1        synchronous active-low reset
//   i_start      in  1        pulse, begins a run when idle
//   i_abort      in  1        level, returns to idle without a done pulse
//   i_mode_mask  in  4        phase enables {LOOP,COUNT,WALK0,WALK1}
//   i_dwell      in  DWELL_W  extra hold cycles per step
//   i_chk_en     in  1        enables the loopback compare
//   i_loop_in    in  8        pin readback
//   o_pat_out    out 8        registered pattern
//   o_pat_oe     out 8        registered output enables
//   o_busy       out 1        high whenever not idle
//   o_done       out 1        one-cycle pulse on normal completion
//   o_pass       out 1        last completed run had no mismatches
//   o_err_cnt    out 8        saturating mismatch count
// ---------------------------------------------------------------------------
module factory_test_sequencer
  import factory_test_pkg::*;
#(
  parameter int DWELL_W    = 8,
  parameter int LOOP_STEPS = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [3:0]         i_mode_mask,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic               i_chk_en,
  input  logic [7:0]         i_loop_in,
  output logic [7:0]         o_pat_out,
  output logic [7:0]         o_pat_oe,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [7:0]         o_err_cnt
);

  localparam logic [7:0]         LOOP_LAST = 8'(LOOP_STEPS - 1);
  localparam logic [DWELL_W-1:0] TIMER_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  logic [2:0]         r_state;
  logic [7:0]         r_step;
  logic [DWELL_W-1:0] r_timer;
  logic [3:0]         r_mask;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_chk;
  logic [7:0]         r_pat_out;
  logic [7:0]         r_pat_oe;
  logic               r_pass;
  logic [7:0]         r_err;

  logic               w_accept;
  logic               w_in_phase;
  logic [7:0]         w_last_step;
  logic [2:0]         w_next_state;
  logic [7:0]         w_next_step;
  logic [DWELL_W-1:0] w_next_timer;
  logic               w_next_pass;
  logic [7:0]         w_next_err;
  logic [7:0]         w_pattern;

  // A start only counts from idle, and an abort in the same cycle vetoes it.
  assign w_accept   = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_in_phase = is_phase(r_state);

  // Index of the final step of whichever phase is currently running.
  always_comb begin
    w_last_step = 8'd0;
    case (r_state)
      ST_WALK1, ST_WALK0: w_last_step = WALK_LAST;
      ST_COUNT:           w_last_step = COUNT_LAST;
      ST_LOOP:            w_last_step = LOOP_LAST;
      default:            w_last_step = 8'd0;
    endcase
  end

  // Mismatch counter. Cleared when a run is accepted; otherwise bumped on the
  // last cycle of a step when the readback disagrees with what is being
  // driven. Nothing is counted in a cycle where the run is being aborted.
  always_comb begin
    w_next_err = r_err;
    if (w_accept) begin
      w_next_err = 8'h00;
    end else if (w_in_phase && !i_abort && (r_timer == '0) && r_chk &&
                 (i_loop_in != r_pat_out) && (r_err != 8'hFF)) begin
      w_next_err = r_err + 8'd1;
    end
  end

  // Sequencer next-state logic. Each step lasts dwell+1 cycles: the timer is
  // reloaded on step entry and the step only advances once it reaches zero.
  // Pass is resolved on the way into FINISH from the updated count, so a
  // mismatch on the very last step is already reflected when done fires.
  always_comb begin
    w_next_state = r_state;
    w_next_step  = r_step;
    w_next_timer = r_timer;
    w_next_pass  = r_pass;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = next_phase(ST_IDLE, i_mode_mask);
          w_next_step  = 8'd0;
          w_next_timer = i_dwell;
          w_next_pass  = 1'b0;
        end
      end
      ST_WALK1, ST_WALK0, ST_COUNT, ST_LOOP: begin
        if (i_abort) begin
          w_next_state = ST_IDLE;
          w_next_step  = 8'd0;
          w_next_pass  = 1'b0;
        end else if (r_timer != '0) begin
          w_next_timer = r_timer - TIMER_ONE;
        end else if (r_step == w_last_step) begin
          w_next_state = next_phase(r_state, r_mask);
          w_next_step  = 8'd0;
          w_next_timer = r_dwell;
        end else begin
          w_next_step  = r_step + 8'd1;
          w_next_timer = r_dwell;
        end
      end
      ST_FINISH: begin
        w_next_state = ST_IDLE;
        if (i_abort) begin
          w_next_pass = 1'b0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_step  = 8'd0;
      end
    endcase
    if ((w_next_state == ST_FINISH) && (r_state != ST_FINISH)) begin
      w_next_pass = (w_next_err == 8'h00);
    end
  end

  // The pattern is looked up from the next state so the registered output
  // lines up with the state it belongs to.
  ft_pattern_gen u_pattern_gen (
    .i_state   (w_next_state),
    .i_step    (w_next_step),
    .o_pattern (w_pattern)
  );

  // State registers. Run configuration is captured only when a run is
  // accepted, so the inputs may change freely while busy.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_step    <= 8'd0;
      r_timer   <= '0;
      r_mask    <= 4'd0;
      r_dwell   <= '0;
      r_chk     <= 1'b0;
      r_pat_out <= 8'h00;
      r_pat_oe  <= 8'h00;
      r_pass    <= 1'b0;
      r_err     <= 8'h00;
    end else begin
      r_state   <= w_next_state;
      r_step    <= w_next_step;
      r_timer   <= w_next_timer;
      r_pass    <= w_next_pass;
      r_err     <= w_next_err;
      r_pat_out <= w_pattern;
      r_pat_oe  <= is_phase(w_next_state) ? 8'hFF : 8'h00;
      if (w_accept) begin
        r_mask  <= i_mode_mask;
        r_dwell <= i_dwell;
        r_chk   <= i_chk_en;
      end
    end
  end

  assign o_pat_out = r_pat_out;
  assign o_pat_oe  = r_pat_oe;
  assign o_busy    = (r_state != ST_IDLE);
  assign o_done    = (r_state == ST_FINISH);
  assign o_pass    = r_pass;
  assign o_err_cnt = r_err;

endmodule

// File: tb/tb_factory_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_factory_test_sequencer
// Scoreboard bench for factory_test_sequencer. The stimulus side builds the
// expected pin sequence of a run from the phase rules (list of patterns, each
// repeated dwell+1 times), decides what the pins read back, and queues the
// expected patterns and the expected end-of-run result. A monitor pops and
// compares whenever the DUT drives a pattern or pulses done.
// ---------------------------------------------------------------------------
module tb_factory_test_sequencer;

  localparam int LOOP_STEPS = 16;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_start;
  logic       i_abort;
  logic [3:0] i_mode_mask;
  logic [7:0] i_dwell;
  logic       i_chk_en;
  logic [7:0] i_loop_in;
  logic [7:0] o_pat_out;
  logic [7:0] o_pat_oe;
  logic       o_busy;
  logic       o_done;
  logic       o_pass;
  logic [7:0] o_err_cnt;

  always #5 clk = ~clk;

  factory_test_sequencer #(
    .DWELL_W    (8),
    .LOOP_STEPS (LOOP_STEPS)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_mode_mask (i_mode_mask),
    .i_dwell     (i_dwell),
    .i_chk_en    (i_chk_en),
    .i_loop_in   (i_loop_in),
    .o_pat_out   (o_pat_out),
    .o_pat_oe    (o_pat_oe),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_pass      (o_pass),
    .o_err_cnt   (o_err_cnt)
  );

  typedef struct { logic [7:0] pat; int cyc; } pat_t;
  typedef struct { logic [7:0] err; logic pass; int busy; int cyc; } res_t;

  pat_t       expPat[$];
  res_t       expRes[$];
  logic [7:0] planPat[$];
  bit         planLast[$];
  logic [7:0] planLoop[$];

  int checkCount = 0;
  int passCount  = 0;
  int cyc        = 0;
  int busyCnt    = 0;
  int lastErr    = 0;

  // Single counted comparison.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    else
      passCount++;
  endtask

  // Counted comparison for a DUT event that nothing was queued for.
  task automatic noteUnexpected(input string name, input logic [31:0] actual);
    checkCount++;
    $display("[TB] FAIL %s: got %0h, expected no event", name, actual);
  endtask

  // Reference pattern for step k of phase p (0=walk1 1=walk0 2=count 3=loop).
  function automatic logic [7:0] refPattern(input int p, input int k);
    logic [7:0] kb;
    kb = 8'(k);
    case (p)
      0:       return 8'(1 << k);
      1:       return ~8'(1 << k);
      2:       return kb;
      default: return {kb[3:0], ~kb[3:0]};
    endcase
  endfunction

  // Whole-run plan: per cycle the driven pattern, whether it is the final
  // cycle of its step, and what the pins read back.
  // mode 0 = perfect loopback, 1 = pins read 0, 2 = random corruption.
  task automatic buildPlan(input logic [3:0] mask, input int dwell, input int mode);
    int lens[4];
    logic [7:0] pat;
    lens = '{8, 8, 256, LOOP_STEPS};
    planPat.delete();
    planLast.delete();
    planLoop.delete();
    for (int p = 0; p < 4; p++) begin
      if (mask[p]) begin
        for (int k = 0; k < lens[p]; k++) begin
          pat = refPattern(p, k);
          for (int d = 0; d <= dwell; d++) begin
            planPat.push_back(pat);
            planLast.push_back(d == dwell);
            if (mode == 0)
              planLoop.push_back(pat);
            else if (mode == 1)
              planLoop.push_back(8'h00);
            else if ($urandom_range(0, 3) == 0)
              planLoop.push_back(pat ^ 8'($urandom_range(1, 255)));
            else
              planLoop.push_back(pat);
          end
        end
      end
    end
  endtask

  // Mismatches seen on step-final cycles among the first n cycles, saturated.
  function automatic int refErr(input bit chk, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++)
      if (chk && planLast[i] && (planLoop[i] != planPat[i])) cnt++;
    return (cnt > 255) ? 255 : cnt;
  endfunction

  // One run. abortAt > 0 raises abort during that run cycle, -1 picks a random
  // abort point (or none). dupAt > 0 pulses start again during that cycle with
  // scrambled settings, which must be ignored.
  task automatic applyStimulus(input logic [3:0] mask, input int dwell, input bit chk,
                               input int mode, input int abortAt, input int dupAt);
    int   total;
    int   n;
    int   expErr;
    int   startCyc;
    int   ab;
    pat_t p;
    res_t r;
    buildPlan(mask, dwell, mode);
    total = planPat.size();
    ab = abortAt;
    if (ab < 0) ab = (total > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, total)) : 0;
    n = (ab > 0) ? ab : total;
    expErr = (ab > 0) ? refErr(chk, ab - 1) : refErr(chk, total);

    @(negedge clk);
    i_mode_mask = mask;
    i_dwell     = 8'(dwell);
    i_chk_en    = chk;
    i_start     = 1'b1;
    startCyc    = cyc;
    for (int i = 0; i < n; i++) begin
      p.pat = planPat[i];
      p.cyc = startCyc + i + 1;
      expPat.push_back(p);
    end
    if (ab == 0) begin
      r.err  = 8'(expErr);
      r.pass = (expErr == 0);
      r.busy = total + 1;
      r.cyc  = startCyc + total + 1;
      expRes.push_back(r);
    end

    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      i_start     = (j == dupAt);
      i_mode_mask = 4'($urandom);
      i_dwell     = 8'($urandom);
      i_chk_en    = 1'($urandom);
      i_loop_in   = planLoop[j-1];
      i_abort     = (j == ab);
    end
    @(negedge clk);
    i_start   = 1'b0;
    i_abort   = 1'b0;
    i_loop_in = 8'h00;
    repeat (3) @(negedge clk);

    checkOutput("patQueueDrained", expPat.size(), 0);
    checkOutput("doneQueueDrained", expRes.size(), 0);
    expPat.delete();
    expRes.delete();
    if (ab > 0) begin
      checkOutput("abortBusy", o_busy, 1'b0);
      checkOutput("abortPatOe", o_pat_oe, 8'h00);
      checkOutput("abortPatOut", o_pat_out, 8'h00);
      checkOutput("abortPass", o_pass, 1'b0);
      checkOutput("abortErrHeld", o_err_cnt, expErr);
    end
    lastErr = expErr;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "PatOut"}, o_pat_out, 8'h00);
    checkOutput({tag, "PatOe"}, o_pat_oe, 8'h00);
    checkOutput({tag, "Busy"}, o_busy, 1'b0);
    checkOutput({tag, "Done"}, o_done, 1'b0);
    checkOutput({tag, "Pass"}, o_pass, 1'b0);
    checkOutput({tag, "ErrCnt"}, o_err_cnt, 8'h00);
  endtask

  // Monitor: samples just after every rising edge and consumes scoreboard
  // entries as the DUT drives patterns and pulses done.
  initial begin
    pat_t p;
    res_t r;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!i_rst_n) begin
        busyCnt = 0;
      end else begin
        if (o_busy) busyCnt++;
        if (o_busy && o_pat_oe == 8'hFF) begin
          if (expPat.size() == 0) begin
            noteUnexpected("unexpectedPattern", o_pat_out);
          end else begin
            p = expPat.pop_front();
            checkOutput("pat_out", o_pat_out, p.pat);
            checkOutput("patCycle", cyc, p.cyc);
          end
        end else if (!o_busy) begin
          checkOutput("idlePatOe", o_pat_oe, 8'h00);
        end
        if (o_done) begin
          if (expRes.size() == 0) begin
            noteUnexpected("unexpectedDone", o_err_cnt);
          end else begin
            r = expRes.pop_front();
            checkOutput("doneErrCnt", o_err_cnt, r.err);
            checkOutput("donePass", o_pass, r.pass);
            checkOutput("doneBusyCycles", busyCnt, r.busy);
            checkOutput("doneCycle", cyc, r.cyc);
            checkOutput("donePatOe", o_pat_oe, 8'h00);
          end
        end
        if (!o_busy) busyCnt = 0;
      end
    end
  end

  initial begin
    int cut;
    pat_t p;
    i_rst_n     = 1'b0;
    i_start     = 1'b0;
    i_abort     = 1'b0;
    i_mode_mask = 4'd0;
    i_dwell     = 8'd0;
    i_chk_en    = 1'b0;
    i_loop_in   = 8'h00;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    i_rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] walk-1 latency run");
    applyStimulus(4'b0001, 0, 1'b0, 0, 0, 0);

    $display("[TB] all phases, dwell 2, ideal loopback");
    applyStimulus(4'b1111, 2, 1'b1, 0, 0, 0);

    $display("[TB] count phase against stuck-low pins, then all phases");
    applyStimulus(4'b0100, 0, 1'b1, 1, 0, 0);
    applyStimulus(4'b1111, 0, 1'b1, 1, 0, 0);

    $display("[TB] abort mid walk-0, then abort+start while idle");
    applyStimulus(4'b0010, 0, 1'b1, 1, 3, 0);
    @(negedge clk);
    i_start = 1'b1;
    i_abort = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abortStartIdleBusy", o_busy, 1'b0);
    checkOutput("abortStartIdleErr", o_err_cnt, lastErr);
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    applyStimulus(4'b0001, 0, 1'b1, 0, 0, 0);

    $display("[TB] empty mask, then restart attempt while busy");
    applyStimulus(4'b0000, 0, 1'b1, 1, 0, 0);
    applyStimulus(4'b0001, 0, 1'b1, 0, 0, 4);

    $display("[TB] reset in the middle of the count phase");
    buildPlan(4'b0111, 0, 1);
    cut = 16 + 41;
    @(negedge clk);
    i_mode_mask = 4'b0111;
    i_dwell     = 8'd0;
    i_chk_en    = 1'b1;
    i_start     = 1'b1;
    for (int i = 0; i < cut; i++) begin
      p.pat = planPat[i];
      p.cyc = cyc + i + 1;
      expPat.push_back(p);
    end
    for (int j = 1; j <= cut; j++) begin
      @(negedge clk);
      i_start   = 1'b0;
      i_loop_in = planLoop[j-1];
      if (j == cut) i_rst_n = 1'b0;
    end
    @(posedge clk);
    #2;
    checkOutput("preResetPatQueueDrained", expPat.size(), 0);
    expPat.delete();
    checkResetValues("midRunReset");
    @(negedge clk);
    i_rst_n   = 1'b1;
    i_loop_in = 8'h00;
    applyStimulus(4'b1111, 1, 1'b1, 2, 0, 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      applyStimulus(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), -1, 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
